// File: rtl/usr_access_pkg.sv
// Shared definitions for the USR_ACCESS reader.
//   state_t          FSM state encoding used by usr_access_reader
//   DEF_*            default parameter values
//   TS_*_LSB         bit positions of the build-timestamp fields inside DATA
//   ts_plausible()   range check of a packed timestamp word
package usr_access_pkg;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_OFFER   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam int DEF_SYNC_STAGES   = 2;
    localparam int DEF_STABLE_CYCLES = 8;
    localparam int DEF_CFGCLK_EDGES  = 4;

    localparam int TS_DAY_LSB   = 27;
    localparam int TS_MONTH_LSB = 23;
    localparam int TS_YEAR_LSB  = 17;
    localparam int TS_HOUR_LSB  = 12;
    localparam int TS_MIN_LSB   = 6;
    localparam int TS_SEC_LSB   = 0;

    // Day field is 5 bits, so only the lower bound needs checking.
    function automatic logic ts_plausible(input logic [31:0] w);
        logic [4:0] day;
        logic [3:0] mon;
        logic [4:0] hour;
        logic [5:0] mins;
        logic [5:0] secs;
        day  = w[TS_DAY_LSB   +: 5];
        mon  = w[TS_MONTH_LSB +: 4];
        hour = w[TS_HOUR_LSB  +: 5];
        mins = w[TS_MIN_LSB   +: 6];
        secs = w[TS_SEC_LSB   +: 6];
        return (day != 5'd0) && (mon != 4'd0) && (mon <= 4'd12) &&
               (hour < 5'd24) && (mins < 6'd60) && (secs < 6'd60);
    endfunction

endpackage

// File: rtl/usr_access_sync.sv
// Single-bit multi-flop synchroniser with edge detection.
//   clk_i   user clock
//   rst_i   synchronous active-high reset
//   d_i     asynchronous input
//   q_o     synchronised level (STAGES flops deep)
//   rise_o  one-cycle pulse on a synchronised 0->1 transition
//   fall_o  one-cycle pulse on a synchronised 1->0 transition
module usr_access_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o =  sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] &  prev_q;

endmodule

// File: rtl/usr_access_reader.sv
// Fabric-side consumer of the USR_ACCESS configuration-data interface.
// Qualifies DATA as stable, offers it once over valid/ready, tracks value
// changes across re-arms and reports CFGCLK activity.
//   CLK, RST            user clock, synchronous active-high reset
//   CFGCLK, DATAVALID   asynchronous primitive strobes (synchronised here)
//   DATA[31:0]          asynchronous primitive word (single capture + stability check)
//   REARM               pulse: drop the result and requalify
//   DOUT, DOUT_VALID,
//   DOUT_READY          qualified word handshake
//   CHANGED             sticky: accepted word differed from the previous one
//   CFGCLK_SEEN         sticky: CFGCLK_EDGES synchronised CFGCLK rises seen
//   BUSY                qualification in progress
// Optional build macro USR_ACCESS_TIMESTAMP_DECODE_EN adds the TS_* outputs,
// decoded from DOUT and updated in the same cycle as DOUT.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_WAIT    | idle, waiting for synchronised DATAVALID
// ST_QUALIFY | counting consecutive identical DATA samples
// ST_OFFER   | DOUT_VALID high until DOUT_READY
// ST_DONE    | word delivered; REARM or DATAVALID low returns to ST_WAIT
module usr_access_reader
    import usr_access_pkg::*;
#(
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CFGCLK_EDGES  = DEF_CFGCLK_EDGES
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CFGCLK,
    input  logic        DATAVALID,
    input  logic [31:0] DATA,
    input  logic        REARM,
    output logic [31:0] DOUT,
    output logic        DOUT_VALID,
    input  logic        DOUT_READY,
    output logic        CHANGED,
    output logic        CFGCLK_SEEN,
    output logic        BUSY
`ifdef USR_ACCESS_TIMESTAMP_DECODE_EN
    ,
    output logic [4:0]  TS_DAY,
    output logic [3:0]  TS_MONTH,
    output logic [5:0]  TS_YEAR,
    output logic [4:0]  TS_HOUR,
    output logic [5:0]  TS_MIN,
    output logic [5:0]  TS_SEC,
    output logic        TS_PLAUSIBLE
`endif
);

    localparam logic [7:0] STABLE_C = 8'(STABLE_CYCLES);
    localparam logic [3:0] EDGES_C  = 4'(CFGCLK_EDGES);

    logic dv_sync, dv_rise, dv_fall;
    logic cc_sync, cc_rise, cc_fall;

    usr_access_sync #(.STAGES(SYNC_STAGES)) u_sync_dv (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (DATAVALID),
        .q_o   (dv_sync),
        .rise_o(dv_rise),
        .fall_o(dv_fall)
    );

    usr_access_sync #(.STAGES(SYNC_STAGES)) u_sync_cc (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (CFGCLK),
        .q_o   (cc_sync),
        .rise_o(cc_rise),
        .fall_o(cc_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{dv_rise, dv_fall, cc_sync, cc_fall};

    state_t      state_q, state_d;
    logic [31:0] dq_q;
    logic [31:0] cand_q, cand_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] dout_q, dout_d;
    logic [31:0] last_q, last_d;
    logic        have_prev_q, have_prev_d;
    logic        changed_q, changed_d;
    logic [3:0]  edge_cnt_q, edge_cnt_d;
    logic        seen_q, seen_d;

    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        dout_d      = dout_q;
        last_d      = last_q;
        have_prev_d = have_prev_q;
        changed_d   = changed_q;

        case (state_q)
            ST_WAIT: begin
                if (REARM) begin
                    cnt_d = 8'd0;
                end else if (dv_sync) begin
                    cand_d  = dq_q;
                    cnt_d   = 8'd1;
                    state_d = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (REARM || !dv_sync) begin
                    cnt_d   = 8'd0;
                    state_d = ST_WAIT;
                end else if (dq_q != cand_q) begin
                    cand_d = dq_q;
                    cnt_d  = 8'd1;
                end else if (cnt_q == STABLE_C) begin
                    dout_d  = cand_q;
                    state_d = ST_OFFER;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_OFFER: begin
                // Valid never retracts here: REARM and DATAVALID only act
                // once the handshake has happened.
                if (DOUT_READY) begin
                    changed_d   = changed_q | (have_prev_q && (dout_q != last_q));
                    last_d      = dout_q;
                    have_prev_d = 1'b1;
                    state_d     = REARM ? ST_WAIT : ST_DONE;
                end
            end
            ST_DONE: begin
                if (REARM || !dv_sync) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_WAIT;
        endcase

        edge_cnt_d = edge_cnt_q;
        if (cc_rise && (edge_cnt_q != 4'hF)) begin
            edge_cnt_d = edge_cnt_q + 4'd1;
        end
        seen_d = seen_q | (edge_cnt_d >= EDGES_C);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_WAIT;
            dq_q        <= '0;
            cand_q      <= '0;
            cnt_q       <= '0;
            dout_q      <= '0;
            last_q      <= '0;
            have_prev_q <= 1'b0;
            changed_q   <= 1'b0;
            edge_cnt_q  <= '0;
            seen_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dq_q        <= DATA;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            dout_q      <= dout_d;
            last_q      <= last_d;
            have_prev_q <= have_prev_d;
            changed_q   <= changed_d;
            edge_cnt_q  <= edge_cnt_d;
            seen_q      <= seen_d;
        end
    end

    assign DOUT        = dout_q;
    assign DOUT_VALID  = (state_q == ST_OFFER);
    assign BUSY        = (state_q == ST_QUALIFY);
    assign CHANGED     = changed_q;
    assign CFGCLK_SEEN = seen_q;

`ifdef USR_ACCESS_TIMESTAMP_DECODE_EN
    logic plaus_q;

    // Evaluated on dout_d so the flag lands in the same cycle as DOUT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            plaus_q <= 1'b0;
        end else begin
            plaus_q <= ts_plausible(dout_d);
        end
    end

    assign TS_DAY       = dout_q[TS_DAY_LSB   +: 5];
    assign TS_MONTH     = dout_q[TS_MONTH_LSB +: 4];
    assign TS_YEAR      = dout_q[TS_YEAR_LSB  +: 6];
    assign TS_HOUR      = dout_q[TS_HOUR_LSB  +: 5];
    assign TS_MIN       = dout_q[TS_MIN_LSB   +: 6];
    assign TS_SEC       = dout_q[TS_SEC_LSB   +: 6];
    assign TS_PLAUSIBLE = plaus_q;
`endif

endmodule

// File: tb/tb_usr_access_reader.sv
`timescale 1ns/1ps
module tb_usr_access_reader;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int EDGES  = 4;

    logic        CLK = 1'b0;
    logic        RST, CFGCLK, DATAVALID, REARM, DOUT_READY;
    logic [31:0] DATA, DOUT;
    logic        DOUT_VALID, CHANGED, CFGCLK_SEEN, BUSY;
`ifdef USR_ACCESS_TIMESTAMP_DECODE_EN
    logic [4:0]  TS_DAY, TS_HOUR;
    logic [3:0]  TS_MONTH;
    logic [5:0]  TS_YEAR, TS_MIN, TS_SEC;
    logic        TS_PLAUSIBLE;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] seq [0:255];

    always #5 CLK = ~CLK;

    usr_access_reader #(
        .SYNC_STAGES  (SYNC),
        .STABLE_CYCLES(STABLE),
        .CFGCLK_EDGES (EDGES)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .CFGCLK     (CFGCLK),
        .DATAVALID  (DATAVALID),
        .DATA       (DATA),
        .REARM      (REARM),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .DOUT_READY (DOUT_READY),
        .CHANGED    (CHANGED),
        .CFGCLK_SEEN(CFGCLK_SEEN),
        .BUSY       (BUSY)
`ifdef USR_ACCESS_TIMESTAMP_DECODE_EN
        ,
        .TS_DAY      (TS_DAY),
        .TS_MONTH    (TS_MONTH),
        .TS_YEAR     (TS_YEAR),
        .TS_HOUR     (TS_HOUR),
        .TS_MIN      (TS_MIN),
        .TS_SEC      (TS_SEC),
        .TS_PLAUSIBLE(TS_PLAUSIBLE)
`endif
    );

    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic do_reset();
        RST = 1'b1; CFGCLK = 1'b0; DATAVALID = 1'b0; DATA = '0;
        REARM = 1'b0; DOUT_READY = 1'b0;
        step(); step();
        RST = 1'b0;
    endtask

    // Reference model. seq[k] is the DATA word present before clock edge k,
    // with DATAVALID raised together with seq[1]. The first word the
    // qualifier can see is seq[SYNC]; a word is accepted once it has been
    // seen on STABLE+1 consecutive samples, and the offer is visible after
    // the edge following the last of those samples. Returns that edge.
    function automatic int model_accept(input int n, output logic [31:0] word);
        logic [31:0] cur;
        int          len;
        word = '0;
        cur  = seq[SYNC];
        len  = 1;
        for (int j = SYNC + 1; j <= n; j++) begin
            if (seq[j] === cur) len++;
            else begin
                cur = seq[j];
                len = 1;
            end
            if (len == STABLE + 1) begin
                word = cur;
                return j + 1;
            end
        end
        return -1;
    endfunction

    // Drives seq[1..n] with DATAVALID high; reports what the DUT did.
    task automatic drive_seq(input int n, input logic ready, input int k_exp,
                             output int first_k, output logic [31:0] word,
                             output int valid_cycles, output logic busy_ok);
        first_k = -1; word = '0; valid_cycles = 0; busy_ok = 1'b1;
        DOUT_READY = ready;
        for (int k = 1; k <= n; k++) begin
            DATAVALID = 1'b1;
            DATA = seq[k];
            step();
            if (DOUT_VALID === 1'b1) begin
                valid_cycles++;
                if (first_k < 0) begin
                    first_k = k;
                    word = DOUT;
                end
            end
            if (k >= SYNC + 1 && k < k_exp && BUSY !== 1'b1) busy_ok = 1'b0;
        end
    endtask

    // Pulses REARM with a new DATA word and waits (bounded) for the next
    // offer, which is accepted with READY high.
    task automatic rearm_accept(input logic [31:0] val, output logic found,
                                output logic [31:0] word);
        found = 1'b0; word = '0;
        DOUT_READY = 1'b1;
        DATA = val;
        REARM = 1'b1;
        step();
        REARM = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            step();
            if (DOUT_VALID === 1'b1) begin
                found = 1'b1;
                word = DOUT;
                step();
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", DOUT_VALID); end
        total++; if (DOUT !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 0", DOUT); end
        total++; if (CHANGED !== 1'b0) begin bad++; $display("FAIL reset_changed: got %b want 0", CHANGED); end
        total++; if (CFGCLK_SEEN !== 1'b0) begin bad++; $display("FAIL reset_seen: got %b want 0", CFGCLK_SEEN); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_latency();
        int fk, vc, kexp;
        logic [31:0] w, wm;
        logic bo;
        do_reset();
        for (int k = 1; k < 40; k++) seq[k] = 32'hA5A5_0001;
        kexp = model_accept(39, wm);
        drive_seq(kexp + 3, 1'b1, kexp, fk, w, vc, bo);
        total++; if (fk !== SYNC + STABLE + 1) begin bad++; $display("FAIL latency_cycle: got %0d want %0d", fk, SYNC + STABLE + 1); end
        total++; if (w !== 32'hA5A5_0001) begin bad++; $display("FAIL latency_dout: got %h want a5a50001", w); end
        total++; if (vc !== 1) begin bad++; $display("FAIL latency_valid_cycles: got %0d want 1", vc); end
        total++; if (CHANGED !== 1'b0) begin bad++; $display("FAIL latency_changed: got %b want 0", CHANGED); end
        total++; if (bo !== 1'b1) begin bad++; $display("FAIL latency_busy: got %b want 1", bo); end
    endtask

    task automatic test_toggle();
        int fk, vc, kexp;
        logic [31:0] w, wm;
        logic bo;
        do_reset();
        for (int k = 1; k <= 30; k++) seq[k] = (((k - 1) / 5) % 2 == 1) ? 32'h1234_5679 : 32'h1234_5678;
        for (int k = 31; k < 80; k++) seq[k] = 32'h1234_5679;
        kexp = model_accept(79, wm);
        drive_seq(kexp + 2, 1'b1, kexp, fk, w, vc, bo);
        total++; if (fk !== kexp) begin bad++; $display("FAIL toggle_cycle: got %0d want %0d", fk, kexp); end
        total++; if (w !== 32'h1234_5679) begin bad++; $display("FAIL toggle_dout: got %h want 12345679", w); end
        total++; if (bo !== 1'b1) begin bad++; $display("FAIL toggle_busy: got %b want 1", bo); end
        total++; if (vc !== 1) begin bad++; $display("FAIL toggle_valid_cycles: got %0d want 1", vc); end
    endtask

    task automatic test_backpressure();
        int fk, vc, kexp;
        logic [31:0] w, wm;
        logic bo, held;
        do_reset();
        for (int k = 1; k < 40; k++) seq[k] = 32'hDEAD_BEEF;
        kexp = model_accept(39, wm);
        drive_seq(kexp, 1'b0, kexp, fk, w, vc, bo);
        total++; if (fk !== kexp) begin bad++; $display("FAIL bp_cycle: got %0d want %0d", fk, kexp); end
        held = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) DATAVALID = 1'b0;
            step();
            if (DOUT_VALID !== 1'b1 || DOUT !== 32'hDEAD_BEEF) held = 1'b0;
        end
        total++; if (held !== 1'b1) begin bad++; $display("FAIL bp_hold: got %b want 1", held); end
        DOUT_READY = 1'b1;
        step();
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL bp_handshake_valid: got %b want 0", DOUT_VALID); end
        total++; if (DOUT !== 32'hDEAD_BEEF) begin bad++; $display("FAIL bp_dout_retained: got %h want deadbeef", DOUT); end
    endtask

    task automatic test_reset_mid_offer();
        int fk, vc, kexp;
        logic [31:0] w, wm;
        logic bo;
        do_reset();
        for (int k = 1; k < 40; k++) seq[k] = 32'h0BAD_F00D;
        kexp = model_accept(39, wm);
        drive_seq(kexp + 1, 1'b0, kexp, fk, w, vc, bo);
        total++; if (DOUT_VALID !== 1'b1) begin bad++; $display("FAIL rst_offer_pre: got %b want 1", DOUT_VALID); end
        RST = 1'b1;
        DOUT_READY = 1'b1;
        step();
        total++; if (DOUT_VALID !== 1'b0) begin bad++; $display("FAIL rst_offer_valid: got %b want 0", DOUT_VALID); end
        total++; if (DOUT !== 32'h0) begin bad++; $display("FAIL rst_offer_dout: got %h want 0", DOUT); end
        RST = 1'b0;
        DATAVALID = 1'b0;
    endtask

    task automatic test_changed();
        int fk, vc, kexp;
        logic [31:0] w, wm;
        logic bo, found;
        do_reset();
        for (int k = 1; k < 40; k++) seq[k] = 32'h0000_0001;
        kexp = model_accept(39, wm);
        drive_seq(kexp + 2, 1'b1, kexp, fk, w, vc, bo);
        total++; if (w !== 32'h1) begin bad++; $display("FAIL chg_first_dout: got %h want 1", w); end
        total++; if (CHANGED !== 1'b0) begin bad++; $display("FAIL chg_first: got %b want 0", CHANGED); end
        rearm_accept(32'h0000_0002, found, w);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL chg_second_timeout: got %b want 1", found); end
        total++; if (w !== 32'h2) begin bad++; $display("FAIL chg_second_dout: got %h want 2", w); end
        total++; if (CHANGED !== 1'b1) begin bad++; $display("FAIL chg_second: got %b want 1", CHANGED); end
        rearm_accept(32'h0000_0002, found, w);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL chg_third_timeout: got %b want 1", found); end
        total++; if (CHANGED !== 1'b1) begin bad++; $display("FAIL chg_sticky: got %b want 1", CHANGED); end
        do_reset();
        for (int k = 1; k < 40; k++) seq[k] = 32'h0000_0005;
        kexp = model_accept(39, wm);
        drive_seq(kexp + 2, 1'b1, kexp, fk, w, vc, bo);
        rearm_accept(32'h0000_0005, found, w);
        total++; if (found !== 1'b1) begin bad++; $display("FAIL chg_equal_timeout: got %b want 1", found); end
        total++; if (CHANGED !== 1'b0) begin bad++; $display("FAIL chg_equal: got %b want 0", CHANGED); end
    endtask

    task automatic test_cfgclk();
        int   rises, r4;
        logic prev, quiet_ok;
        do_reset();
        quiet_ok = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (CFGCLK_SEEN !== 1'b0) quiet_ok = 1'b0;
        end
        total++; if (quiet_ok !== 1'b1) begin bad++; $display("FAIL cfgclk_quiet: got %b want 1", quiet_ok); end
        rises = 0; r4 = -1; prev = 1'b0;
        for (int c = 0; c < 60; c++) begin
            CFGCLK = ((c % 7) < 3);
            if (CFGCLK && !prev) begin
                rises++;
                if (rises == EDGES) r4 = c;
            end
            prev = CFGCLK;
            step();
            if (c == r4) begin
                total++; if (CFGCLK_SEEN !== 1'b0) begin bad++; $display("FAIL cfgclk_early: got %b want 0", CFGCLK_SEEN); end
            end
            if (r4 >= 0 && c == r4 + SYNC + 1) begin
                total++; if (CFGCLK_SEEN !== 1'b1) begin bad++; $display("FAIL cfgclk_seen: got %b want 1", CFGCLK_SEEN); end
            end
        end
        CFGCLK = 1'b0;
        REARM = 1'b1;
        step();
        REARM = 1'b0;
        step();
        total++; if (CFGCLK_SEEN !== 1'b1) begin bad++; $display("FAIL cfgclk_rearm: got %b want 1", CFGCLK_SEEN); end
    endtask

    task automatic test_random();
        int fk, vc, kexp, k, len;
        logic [31:0] w, wm, base, v;
        logic bo;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            base = $urandom;
            k = 1;
            while (k <= 100) begin
                v = base ^ 32'($urandom_range(0, 3));
                len = $urandom_range(1, 12);
                for (int i = 0; i < len && k <= 100; i++) begin
                    seq[k] = v;
                    k++;
                end
            end
            v = $urandom;
            for (int j = 101; j < 140; j++) seq[j] = v;
            kexp = model_accept(139, wm);
            drive_seq(kexp + 1, 1'b1, kexp, fk, w, vc, bo);
            total++; if (fk !== kexp) begin bad++; $display("FAIL rand_cycle[%0d]: got %0d want %0d", it, fk, kexp); end
            total++; if (w !== wm) begin bad++; $display("FAIL rand_dout[%0d]: got %h want %h", it, w, wm); end
            total++; if (vc !== 1) begin bad++; $display("FAIL rand_valid_cycles[%0d]: got %0d want 1", it, vc); end
        end
    endtask

`ifdef USR_ACCESS_TIMESTAMP_DECODE_EN
    task automatic test_timestamp();
        int fk, vc, kexp;
        logic [31:0] w, wm, rw;
        logic bo, pl;
        do_reset();
        for (int k = 1; k < 40; k++) seq[k] = 32'h9392_D79E;
        kexp = model_accept(39, wm);
        drive_seq(kexp + 1, 1'b0, kexp, fk, w, vc, bo);
        total++; if (TS_DAY !== 5'd18) begin bad++; $display("FAIL ts_day: got %0d want 18", TS_DAY); end
        total++; if (TS_MONTH !== 4'd7) begin bad++; $display("FAIL ts_month: got %0d want 7", TS_MONTH); end
        total++; if (TS_YEAR !== 6'd9) begin bad++; $display("FAIL ts_year: got %0d want 9", TS_YEAR); end
        total++; if (TS_HOUR !== 5'd13) begin bad++; $display("FAIL ts_hour: got %0d want 13", TS_HOUR); end
        total++; if (TS_MIN !== 6'd30) begin bad++; $display("FAIL ts_min: got %0d want 30", TS_MIN); end
        total++; if (TS_SEC !== 6'd30) begin bad++; $display("FAIL ts_sec: got %0d want 30", TS_SEC); end
        total++; if (TS_PLAUSIBLE !== 1'b1) begin bad++; $display("FAIL ts_plausible: got %b want 1", TS_PLAUSIBLE); end
        do_reset();
        for (int k = 1; k < 40; k++) seq[k] = 32'h0;
        kexp = model_accept(39, wm);
        drive_seq(kexp + 1, 1'b0, kexp, fk, w, vc, bo);
        total++; if (DOUT_VALID !== 1'b1) begin bad++; $display("FAIL ts_zero_valid: got %b want 1", DOUT_VALID); end
        total++; if (TS_PLAUSIBLE !== 1'b0) begin bad++; $display("FAIL ts_zero_plausible: got %b want 0", TS_PLAUSIBLE); end
        for (int it = 0; it < 3; it++) begin
            do_reset();
            rw = $urandom;
            for (int k = 1; k < 40; k++) seq[k] = rw;
            kexp = model_accept(39, wm);
            drive_seq(kexp + 1, 1'b0, kexp, fk, w, vc, bo);
            pl = ((rw / 32'd134217728) != 0) &&
                 (((rw / 32'd8388608) % 16) >= 1) && (((rw / 32'd8388608) % 16) <= 12) &&
                 (((rw / 32'd4096) % 32) < 24) &&
                 (((rw / 32'd64) % 64) < 60) && ((rw % 64) < 60);
            total++; if (TS_HOUR !== 5'((rw / 32'd4096) % 32)) begin bad++; $display("FAIL ts_rand_hour[%0d]: got %0d want %0d", it, TS_HOUR, (rw / 32'd4096) % 32); end
            total++; if (TS_PLAUSIBLE !== pl) begin bad++; $display("FAIL ts_rand_plausible[%0d]: got %b want %b", it, TS_PLAUSIBLE, pl); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_toggle();
        test_backpressure();
        test_reset_mid_offer();
        test_changed();
        test_cfgclk();
        test_random();
`ifdef USR_ACCESS_TIMESTAMP_DECODE_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
